// File: rtl/clock_set_controller.sv
// clock_set_controller: push-button front end for the hh:mm:ss counter.
// Pauses the counter, edits hours then minutes, then commits the new time
// with a one-cycle load strobe.
// Optional feature macro: CLOCK_SET_AUTOREPEAT_EN. When it is defined, a held
// inc button repeats every REPEAT_CYCLES cycles while a field is being edited.

// Per-button conditioning: 2-flop synchroniser, debouncer, rising-edge pulse.
module clock_set_btn #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_q;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else      sync <= {sync[0], raw};
  end

  // The level changes only after the synchronised value has disagreed with it
  // for DEB_CYCLES cycles in a row; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync[1] != level) begin
      if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Registered one-cycle pulse on a 0->1 transition of the debounced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end
endmodule

module clock_set_controller #(
  parameter int DEB_CYCLES    = 1000000,
  parameter int BLINK_CYCLES  = 50000000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_h,
  input  logic [5:0] cur_m,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_h,
  output logic [5:0] load_m,
  output logic [5:0] load_s,
  output logic [1:0] sel,
  output logic       blink
);
  localparam int NUM_BTN = 2;
  localparam int BW      = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  // Parameter sanity check at elaboration time.
  if (DEB_CYCLES < 1 || BLINK_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("clock_set_controller: cycle parameters must be >= 1");
  end

  typedef enum logic [1:0] {RUN, SET_H, SET_M, COMMIT} state_t;

  state_t state, nxt;

  // Button 0 = mode, button 1 = inc.
  logic [NUM_BTN-1:0] raw_v, lvl_v, prs_v;
  assign raw_v = {btn_inc, btn_mode};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    clock_set_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_v[gi]),
      .level(lvl_v[gi]),
      .press(prs_v[gi])
    );
  end

  logic mode_p, inc_p, inc_lvl, editing, rep, inc_evt;
  assign mode_p  = prs_v[0];
  assign inc_p   = prs_v[1];
  assign inc_lvl = lvl_v[1];
  assign editing = (state == SET_H) || (state == SET_M);
  assign inc_evt = inc_p | rep;

  // The mode level is never needed; keep it visible as an intentional sink.
  logic unused_lvl;
  assign unused_lvl = ^{lvl_v[0], inc_lvl};

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [RW-1:0] rcnt;

  assign rep = editing && inc_lvl && !inc_p && (rcnt == RW'(REPEAT_CYCLES - 1));

  // Repeat timer: restarts on the initial press and after each repeat, and is
  // held clear on release, outside the edit states, or on any state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                              rcnt <= '0;
    else if (!editing || !inc_lvl || nxt != state || inc_p || rep) rcnt <= '0;
    else                                                   rcnt <= rcnt + RW'(1);
  end
`else
  assign rep = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= nxt;
  end

  // Next state and state-decoded outputs; mode always takes priority over inc.
  always_comb begin
    nxt    = state;
    run_en = 1'b1;
    load   = 1'b0;
    sel    = 2'b00;
    case (state)
      RUN: begin
        if (mode_p) nxt = SET_H;
      end
      SET_H: begin
        run_en = 1'b0;
        sel    = 2'b01;
        if (mode_p) nxt = SET_M;
      end
      SET_M: begin
        run_en = 1'b0;
        sel    = 2'b10;
        if (mode_p) nxt = COMMIT;
      end
      COMMIT: begin
        run_en = 1'b0;
        load   = 1'b1;
        nxt    = RUN;
      end
      default: nxt = RUN;
    endcase
  end

  // Edit registers: capture live time on entry (out-of-range reads as 0),
  // then wrap-increment the selected field. No carry between fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_h <= '0;
      load_m <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mode_p) begin
            load_h <= (cur_h > 5'd23) ? 5'd0 : cur_h;
            load_m <= (cur_m > 6'd59) ? 6'd0 : cur_m;
          end
        end
        SET_H: begin
          if (!mode_p && inc_evt) load_h <= (load_h == 5'd23) ? 5'd0 : load_h + 5'd1;
        end
        SET_M: begin
          if (!mode_p && inc_evt) load_m <= (load_m == 6'd59) ? 6'd0 : load_m + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign load_s = '0;

  logic [BW-1:0] bcnt;

  // Blink phase: restarts dark on entry to an edit state, toggles every
  // BLINK_CYCLES cycles while editing, held off elsewhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if ((nxt == SET_H || nxt == SET_M) && nxt != state) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (editing) begin
      if (bcnt == BW'(BLINK_CYCLES - 1)) begin
        bcnt  <= '0;
        blink <= ~blink;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end else begin
      bcnt  <= '0;
      blink <= 1'b0;
    end
  end
endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller with short debounce/blink/repeat
// periods. Commit strobes are checked against a queue of expected load values.
module tb_clock_set_controller;
  localparam int DEB    = 4;
  localparam int BLINK  = 8;
  localparam int REPEAT = 16;
  localparam int HOLD   = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0;
  logic [4:0] cur_h = '0;
  logic [5:0] cur_m = '0;
  logic       run_en, load, blink;
  logic [4:0] load_h;
  logic [5:0] load_m, load_s;
  logic [1:0] sel;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [4:0] h; logic [5:0] m; } exp_t;
  exp_t sbq[$];
  logic load_prev = 1'b0;

  clock_set_controller #(.DEB_CYCLES(DEB), .BLINK_CYCLES(BLINK), .REPEAT_CYCLES(REPEAT)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_h(cur_h), .cur_m(cur_m), .run_en(run_en), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s), .sel(sel), .blink(blink)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every load strobe must match the oldest expectation,
  // last exactly one cycle, and come with run_en=0, sel=00, load_s=0.
  always @(negedge clk) begin
    exp_t e;
    if (rst && load) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected: load=1 with h=%0d m=%0d, none expected", load_h, load_m);
      end else begin
        e = sbq.pop_front();
        if ({load_prev, load_h, load_m, load_s, run_en, sel} !== {1'b0, e.h, e.m, 6'd0, 1'b0, 2'b00}) begin
          errors++;
          $display("FAIL load_value: got prev=%b h=%0d m=%0d s=%0d run=%b sel=%b, want prev=0 h=%0d m=%0d s=0 run=0 sel=00",
                   load_prev, load_h, load_m, load_s, run_en, sel, e.h, e.m);
        end
      end
    end
    load_prev = load;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m; btn_inc = i;
    cyc(HOLD);
    btn_mode = 1'b0; btn_inc = 1'b0;
    cyc(HOLD);
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    cyc(3);
    checks++;
    if ({run_en, load, sel, blink, load_h, load_m, load_s} !== {1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL reset_held: run=%b load=%b sel=%b blink=%b h=%0d m=%0d s=%0d", run_en, load, sel, blink, load_h, load_m, load_s);
    end
    rst = 1'b1;
    cyc(2);
    checks++;
    if ({run_en, load, sel, blink, load_h, load_m} !== {1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 6'd0}) begin
      errors++;
      $display("FAIL reset_release: run=%b load=%b sel=%b blink=%b h=%0d m=%0d", run_en, load, sel, blink, load_h, load_m);
    end
    btn_mode = 1'b1; cyc(3); btn_mode = 1'b0; cyc(HOLD);
    checks++;
    if ({sel, run_en} !== {2'b00, 1'b1}) begin
      errors++;
      $display("FAIL short_press: sel=%b run=%b, want sel=00 run=1", sel, run_en);
    end
  endtask

  task automatic test_edit_wrap;
    cur_h = 5'd22; cur_m = 6'd58;
    press(1'b1, 1'b0);
    checks++;
    if ({sel, run_en, load_h, load_m} !== {2'b01, 1'b0, 5'd22, 6'd58}) begin
      errors++;
      $display("FAIL enter_set_h: sel=%b run=%b h=%0d m=%0d, want 01 0 22 58", sel, run_en, load_h, load_m);
    end
    press(1'b0, 1'b1);
    checks++;
    if (load_h !== 5'd23) begin errors++; $display("FAIL inc_h_23: h=%0d want 23", load_h); end
    press(1'b0, 1'b1);
    checks++;
    if (load_h !== 5'd0) begin errors++; $display("FAIL inc_h_wrap: h=%0d want 0", load_h); end
    press(1'b1, 1'b0);
    checks++;
    if ({sel, run_en} !== {2'b10, 1'b0}) begin errors++; $display("FAIL enter_set_m: sel=%b run=%b want 10 0", sel, run_en); end
    press(1'b0, 1'b1);
    checks++;
    if (load_m !== 6'd59) begin errors++; $display("FAIL inc_m_59: m=%0d want 59", load_m); end
    press(1'b0, 1'b1);
    checks++;
    if ({load_m, load_h} !== {6'd0, 5'd0}) begin errors++; $display("FAIL inc_m_wrap: m=%0d h=%0d want 0 0", load_m, load_h); end
    sbq.push_back('{h: 5'd0, m: 6'd0});
    press(1'b1, 1'b0);
    checks++;
    if ({sel, run_en, load, sbq.size() == 0} !== {2'b00, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL commit_return: sel=%b run=%b load=%b pending=%0d", sel, run_en, load, sbq.size());
    end
  endtask

  task automatic test_bounce;
    cur_h = 5'd5; cur_m = 6'd10;
    press(1'b1, 1'b0);
    checks++;
    if ({sel, load_h} !== {2'b01, 5'd5}) begin errors++; $display("FAIL bounce_entry: sel=%b h=%0d want 01 5", sel, load_h); end
    for (int n = 0; n < 5; n++) begin
      btn_inc = 1'b1; cyc(2);
      btn_inc = 1'b0; cyc(2);
    end
    press(1'b0, 1'b1);
    checks++;
    if (load_h !== 5'd6) begin errors++; $display("FAIL bounce_single: h=%0d want 6", load_h); end
  endtask

  task automatic test_simultaneous;
    press(1'b1, 1'b1);
    checks++;
    if ({sel, load_h, load_m} !== {2'b10, 5'd6, 6'd10}) begin
      errors++;
      $display("FAIL simul_mode_wins: sel=%b h=%0d m=%0d want 10 6 10", sel, load_h, load_m);
    end
    sbq.push_back('{h: 5'd6, m: 6'd10});
    press(1'b1, 1'b0);
    checks++;
    if ({sel, run_en, sbq.size() == 0} !== {2'b00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL simul_commit: sel=%b run=%b pending=%0d", sel, run_en, sbq.size());
    end
  endtask

  task automatic test_blink_reset;
    bit found;
    logic exp_b;
    cur_h = 5'd27; cur_m = 6'd61;
    press(1'b1, 1'b0);
    checks++;
    if ({sel, load_h, load_m} !== {2'b01, 5'd0, 6'd0}) begin
      errors++;
      $display("FAIL range_capture: sel=%b h=%0d m=%0d want 01 0 0", sel, load_h, load_m);
    end
    btn_mode = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      cyc(1);
      if (sel === 2'b10) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL blink_entry_timeout: sel=%b want 10", sel); end
    btn_mode = 1'b0;
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) cyc(1);
      exp_b = ((k / BLINK) % 2) == 1;
      checks++;
      if (blink !== exp_b) begin errors++; $display("FAIL blink_k%0d: blink=%b want %b", k, blink, exp_b); end
    end
    rst = 1'b0;
    cyc(2);
    checks++;
    if ({run_en, load, sel, blink, load_h, load_m} !== {1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 6'd0}) begin
      errors++;
      $display("FAIL reset_mid_edit: run=%b load=%b sel=%b blink=%b h=%0d m=%0d", run_en, load, sel, blink, load_h, load_m);
    end
    rst = 1'b1;
    cyc(3);
    checks++;
    if ({run_en, load, sel, blink} !== {1'b1, 1'b0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_edit_release: run=%b load=%b sel=%b blink=%b", run_en, load, sel, blink);
    end
  endtask

  task automatic test_autorepeat;
    bit found;
    int nchg;
    logic [5:0] last;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    logic [5:0] exp_m = 6'd0;
    int exp_n = 2;
`else
    logic [5:0] exp_m = 6'd58;
    int exp_n = 0;
`endif
    cur_h = 5'd1; cur_m = 6'd57;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    checks++;
    if ({sel, load_m} !== {2'b10, 6'd57}) begin errors++; $display("FAIL rep_entry: sel=%b m=%0d want 10 57", sel, load_m); end
    btn_inc = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      cyc(1);
      if (load_m !== 6'd57) found = 1'b1;
    end
    checks++;
    if (!found || load_m !== 6'd58) begin errors++; $display("FAIL rep_first: m=%0d want 58", load_m); end
    last = load_m; nchg = 0;
    for (int n = 0; n < 40; n++) begin
      cyc(1);
      if (load_m !== last) begin nchg++; last = load_m; end
    end
    btn_inc = 1'b0;
    for (int n = 0; n < 15; n++) begin
      cyc(1);
      if (load_m !== last) begin nchg++; last = load_m; end
    end
    checks++;
    if (load_m !== exp_m || nchg != exp_n) begin
      errors++;
      $display("FAIL rep_hold: m=%0d changes=%0d want m=%0d changes=%0d", load_m, nchg, exp_m, exp_n);
    end
    sbq.push_back('{h: 5'd1, m: exp_m});
    press(1'b1, 1'b0);
    checks++;
    if ({sel, run_en, sbq.size() == 0} !== {2'b00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rep_commit: sel=%b run=%b pending=%0d", sel, run_en, sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_edit_wrap();
    test_bounce();
    test_simultaneous();
    test_blink_reset();
    test_autorepeat();
    cyc(5);
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d loads never seen", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Button-driven controller that sequences the hh:mm:ss timekeeping datapath: pauses counting, lets the user edit hours then minutes, and commits the new time with a one-cycle load strobe.
- Sits between the board push-buttons and the timekeeping counter. Its blink and field-select outputs feed the seven-segment interface.

Parameters:
- DEB_CYCLES, 1000000: consecutive stable cycles required before a synchronised button level is accepted (10 ms at 100 MHz).
- BLINK_CYCLES, 50000000: half-period of the blink output while editing, in cycles.
- REPEAT_CYCLES, 25000000: auto-repeat interval for a held inc button (used only with the optional feature).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw mode push-button, asynchronous, active-high.
- btn_inc  in  1  raw increment push-button, asynchronous, active-high.
- cur_h  in  5  live hours from the timekeeping counter, 0-23.
- cur_m  in  6  live minutes from the timekeeping counter, 0-59.
- run_en  out  1  1 = timekeeping counter may advance.
- load  out  1  one-cycle strobe: counter takes load_h/load_m/load_s.
- load_h  out  5  edited hours value.
- load_m  out  6  edited minutes value.
- load_s  out  6  seconds to load, constant 0.
- sel  out  2  field being edited: 00 none, 01 hours, 10 minutes.
- blink  out  1  blanking phase for the selected field.

Behaviour:
- Reset (rst=0) values:
  - outputs: run_en=1, load=0, load_h=0, load_m=0, load_s=0, sel=00, blink=0.
  - internal: state=RUN, all counters 0, debounced levels 0.
- Input conditioning, per button:
  - 2-flop synchroniser, then debouncer.
  - The debounced level takes the synchronised value only after that value has differed from it for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
  - press = one-cycle pulse on a 0->1 transition of the debounced level.
  - Latency from a clean raw edge to the press pulse: DEB_CYCLES+3 cycles.
- FSM states: RUN, SET_H, SET_M, COMMIT.
  - RUN: run_en=1, sel=00, blink=0.
    - mode press -> SET_H. On the same edge, capture cur_h/cur_m into the edit registers; values out of range (h>23, m>59) are captured as 0.
    - run_en drops to 0 in the first SET_H cycle.
  - SET_H: run_en=0, sel=01.
    - inc press: load_h = (load_h==23) ? 0 : load_h+1.
    - mode press -> SET_M.
  - SET_M: run_en=0, sel=10.
    - inc press: load_m = (load_m==59) ? 0 : load_m+1.
    - mode press -> COMMIT.
  - COMMIT: exactly one cycle; load=1, run_en=0, sel=00. Next state RUN, with run_en=1 from the following cycle.
- Simultaneous mode and inc press in the same cycle: mode wins, inc is discarded.
- inc press in RUN or COMMIT is ignored.
- load_h/load_m always drive the edit registers, so the display can show them while editing. They are meaningful to the counter only when load=1.
- Blink:
  - The blink counter clears and blink=0 on entry to SET_H or SET_M.
  - While in those states, blink toggles every BLINK_CYCLES cycles.
  - Forced to 0 in RUN and COMMIT.
- Reset mid-edit: discard the edit, no load pulse, return to the reset values.
- Width rules: all arithmetic is unsigned at the field width, with explicit wrap. No carry from minutes into hours while editing.

Optional Feature:
- Macro: CLOCK_SET_AUTOREPEAT_EN.
- Defined:
  - In SET_H/SET_M, while the debounced inc level stays 1, an extra increment fires every REPEAT_CYCLES cycles after the initial press.
  - The repeat counter clears on release or on any state change.
  - Wrap rules are the same as for a single press.
- Undefined: one increment per press only. The repeat counter and REPEAT_CYCLES are unused and no logic is generated for them.

Test Plan (bench overrides: DEB_CYCLES=4, BLINK_CYCLES=8, REPEAT_CYCLES=16):
- Reset then release rst:
  - expect run_en=1, load=0, sel=00, blink=0, load_h=0, load_m=0.
  - btn_mode high for 3 cycles then low: no state change.
- cur_h=22, cur_m=58; press mode -> SET_H, sel=01, run_en=0, load_h=22, load_m=58.
  - press inc twice -> load_h=23, then 0.
  - press mode -> SET_M; press inc twice -> load_m=59, then 0.
  - press mode -> exactly one cycle with load=1, load_h=0, load_m=0, load_s=0, then run_en=1, sel=00.
- Bounce on btn_inc in SET_H (toggle every 2 cycles for 20 cycles, then hold high) -> exactly one increment.
- btn_mode and btn_inc debounced in the same cycle while in SET_H -> state SET_M, load_h unchanged.
- cur_h=27, cur_m=61 captured -> load_h=0, load_m=0.
  - in SET_M, blink toggles at cycles 8, 16, 24 after entry.
  - assert rst in SET_M -> no load pulse, all outputs at reset values.
- CLOCK_SET_AUTOREPEAT_EN defined: in SET_M from load_m=57, hold inc for 40 cycles past the press -> load_m 58, 59, 0 (press plus 2 repeats).
  - Undefined: same stimulus -> load_m=58 only.
